// File: rtl/iecdrv_pkg.sv
// Shared types for the SD request arbiter: FSM states and drive index type.
package iecdrv_pkg;

    typedef enum logic [1:0] {IDLE, REQ, XFER, REL} arb_state_t;

    localparam int MAX_DRV = 4;

    typedef logic [1:0] drv_idx_t;

endpackage

// File: rtl/iecdrv_rr_pick.sv
// Combinational round-robin picker: first requester after rr_ptr, with wrap.
// Zero latency; purely combinational, no flow control of its own.
module iecdrv_rr_pick
    import iecdrv_pkg::*;
#(
    parameter int NDR = 2
) (
    input  logic [NDR-1:0] req,
    input  drv_idx_t       rr_ptr,
    output logic           valid,
    output drv_idx_t       idx
);

    // Walk offsets from farthest to nearest so the nearest requester lands last.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int k = NDR; k >= 1; k--) begin
            for (int j = 0; j < NDR; j++) begin
                if (req[j] && (((int'(rr_ptr) + k) % NDR) == j)) begin
                    valid = 1'b1;
                    idx   = drv_idx_t'(j);
                end
            end
        end
    end

endmodule

// File: rtl/iecdrv_sd_arbiter.sv
// Merges per-drive SD sector requests onto one host channel; grant held for a whole sector.
// Request seen in IDLE issues on the next edge; ack and buffer data are routed combinationally.
module iecdrv_sd_arbiter
    import iecdrv_pkg::*;
#(
    parameter int          NDR     = 2,
    parameter logic [23:0] TIMEOUT = 24'd16000000
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic [32*NDR-1:0] drv_lba,
    input  logic [NDR-1:0]    drv_rd,
    input  logic [NDR-1:0]    drv_wr,
    output logic [NDR-1:0]    drv_ack,
    input  logic [8*NDR-1:0]  drv_buff_din,
    output logic [31:0]       sd_lba,
    output logic              sd_rd,
    output logic              sd_wr,
    input  logic              sd_ack,
    output logic [7:0]        sd_buff_din,
    output logic [1:0]        sd_drv,
    output logic              busy,
    output logic              timeout_err
);

    localparam drv_idx_t LAST_DRV = drv_idx_t'(NDR - 1);

    arb_state_t  state_q, state_d;
    drv_idx_t    grant_q, grant_d;
    drv_idx_t    rr_q, rr_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic [31:0] lba_q, lba_d;
    logic [23:0] cnt_q, cnt_d;
    logic        terr_q, terr_d;

    logic        pick_vld;
    drv_idx_t    pick_idx;
    logic [31:0] pick_lba;
    logic        pick_wr;
    logic        ack_phase;

    iecdrv_rr_pick #(.NDR(NDR)) u_pick (
        .req    (drv_rd | drv_wr),
        .rr_ptr (rr_q),
        .valid  (pick_vld),
        .idx    (pick_idx)
    );

    assign ack_phase = (state_q == REQ) || (state_q == XFER);

    always_comb begin
        pick_lba    = '0;
        pick_wr     = 1'b0;
        sd_buff_din = '0;
        drv_ack     = '0;
        for (int i = 0; i < NDR; i++) begin
            if (pick_idx == drv_idx_t'(i)) begin
                pick_lba = drv_lba[32*i +: 32];
                pick_wr  = drv_wr[i];
            end
            if (grant_q == drv_idx_t'(i)) begin
                sd_buff_din = drv_buff_din[8*i +: 8];
                drv_ack[i]  = sd_ack & ack_phase;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        lba_d   = lba_q;
        cnt_d   = cnt_q;
        terr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    grant_d = pick_idx;
                    lba_d   = pick_lba;
                    wr_d    = pick_wr;
                    rd_d    = ~pick_wr;
                    cnt_d   = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (sd_ack) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    state_d = XFER;
                end else if ((TIMEOUT != '0) && (cnt_q == TIMEOUT - 24'd1)) begin
                    // Host never answered: drop the request and move on to the next drive.
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    terr_d  = 1'b1;
                    rr_d    = grant_q;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 24'd1;
                end
            end
            XFER: begin
                if (!sd_ack) state_d = REL;
            end
            REL: begin
                rr_d    = grant_q;
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            rr_q    <= LAST_DRV;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            lba_q   <= '0;
            cnt_q   <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            lba_q   <= lba_d;
            cnt_q   <= cnt_d;
            terr_q  <= terr_d;
        end
    end

    assign sd_lba      = lba_q;
    assign sd_rd       = rd_q;
    assign sd_wr       = wr_q;
    assign sd_drv      = grant_q;
    assign busy        = (state_q != IDLE);
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_iecdrv_sd_arbiter.sv
// Randomized bench for iecdrv_sd_arbiter: the bench acts as host and checks every
// transaction against a round-robin reference model of which drive should be served.
module tb_iecdrv_sd_arbiter;

    localparam int NDR = 2;
    localparam int TO  = 100;

    logic              clk_sys = 1'b0;
    logic              reset_n = 1'b0;
    logic [32*NDR-1:0] drv_lba = '0;
    logic [NDR-1:0]    drv_rd = '0;
    logic [NDR-1:0]    drv_wr = '0;
    logic [NDR-1:0]    drv_ack;
    logic [8*NDR-1:0]  drv_buff_din = '0;
    logic [31:0]       sd_lba;
    logic              sd_rd;
    logic              sd_wr;
    logic              sd_ack = 1'b0;
    logic [7:0]        sd_buff_din;
    logic [1:0]        sd_drv;
    logic              busy;
    logic              timeout_err;

    int n_chk  = 0;
    int n_pass = 0;
    int last_srv = NDR - 1;

    iecdrv_sd_arbiter #(.NDR(NDR), .TIMEOUT(24'd100)) dut (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .drv_lba      (drv_lba),
        .drv_rd       (drv_rd),
        .drv_wr       (drv_wr),
        .drv_ack      (drv_ack),
        .drv_buff_din (drv_buff_din),
        .sd_lba       (sd_lba),
        .sd_rd        (sd_rd),
        .sd_wr        (sd_wr),
        .sd_ack       (sd_ack),
        .sd_buff_din  (sd_buff_din),
        .sd_drv       (sd_drv),
        .busy         (busy),
        .timeout_err  (timeout_err)
    );

    always #5 clk_sys = ~clk_sys;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // Reference: the next drive served is the first requester after the last one served.
    function automatic int rr_winner(input logic [NDR-1:0] req);
        for (int k = 1; k <= NDR; k++) begin
            if (req[(last_srv + k) % NDR]) return (last_srv + k) % NDR;
        end
        return -1;
    endfunction

    // dly < 0 means the host never acks, so the request must time out.
    task automatic run_txn(input logic [NDR-1:0] rd, input logic [NDR-1:0] wr,
                           input logic [63:0] lba, input logic [15:0] din,
                           input int dly, input int len, input bit withdraw, input bit stray);
        int            w;
        int            n;
        bit            is_wr;
        logic [31:0]   exp_lba;
        logic [7:0]    exp_din;
        logic [1:0]    exp_dir;
        logic [NDR-1:0] oh;
        drv_rd       = rd;
        drv_wr       = wr;
        drv_lba      = lba;
        drv_buff_din = din;
        sd_ack       = 1'b0;
        w = rr_winner(rd | wr);
        tick();
        if (w < 0) begin
            chk("noreq_busy", busy, 0);
            chk("noreq_dir", {sd_rd, sd_wr}, 0);
            return;
        end
        is_wr   = wr[w];
        exp_lba = lba[32*w +: 32];
        exp_din = din[8*w +: 8];
        exp_dir = is_wr ? 2'b01 : 2'b10;
        oh      = '0;
        oh[w]   = 1'b1;
        chk("issue_dir", {sd_rd, sd_wr}, exp_dir);
        chk("issue_lba", sd_lba, exp_lba);
        chk("issue_drv", sd_drv, w);
        chk("issue_busy", busy, 1);
        chk("issue_terr", timeout_err, 0);
        if (withdraw) begin
            drv_rd  = '0;
            drv_wr  = '0;
            drv_lba = ~lba;
        end
        if (dly < 0) begin
            n = 0;
            for (int i = 1; i <= 2 * TO; i++) begin
                tick();
                if (!sd_rd && !sd_wr) begin
                    n = i;
                    break;
                end
            end
            chk("to_latency", n, TO);
            chk("to_err", timeout_err, 1);
            chk("to_busy", busy, 0);
            drv_rd = '0;
            drv_wr = '0;
            sd_ack = 1'b1;
            #1;
            chk("stray_ack_idle", drv_ack, 0);
            tick();
            chk("to_err_pulse", timeout_err, 0);
            chk("stray_busy", busy, 0);
            chk("stray_dir", {sd_rd, sd_wr}, 0);
            sd_ack = 1'b0;
            last_srv = w;
            return;
        end
        repeat (dly) begin
            tick();
            chk("req_hold_dir", {sd_rd, sd_wr}, exp_dir);
            chk("req_hold_lba", sd_lba, exp_lba);
        end
        sd_ack = 1'b1;
        #1;
        chk("ack_route", drv_ack, oh);
        chk("din_mux", sd_buff_din, exp_din);
        repeat (len) begin
            tick();
            chk("xfer_dir", {sd_rd, sd_wr}, 0);
            chk("xfer_ack", drv_ack, oh);
            chk("xfer_din", sd_buff_din, exp_din);
            chk("xfer_drv", sd_drv, w);
        end
        sd_ack = 1'b0;
        #1;
        chk("ack_low", drv_ack, 0);
        tick();
        chk("rel_busy", busy, 1);
        sd_ack = stray;
        #1;
        chk("rel_ack", drv_ack, 0);
        tick();
        chk("gap_busy", busy, 0);
        chk("gap_ack", drv_ack, 0);
        chk("gap_dir", {sd_rd, sd_wr}, 0);
        sd_ack = 1'b0;
        last_srv = w;
    endtask

    initial begin
        logic [NDR-1:0] rd;
        logic [NDR-1:0] wr;
        int             dly;

        repeat (2) tick();
        chk("rst_busy", busy, 0);
        chk("rst_dir", {sd_rd, sd_wr}, 0);
        chk("rst_lba", sd_lba, 0);
        chk("rst_drv", sd_drv, 0);
        chk("rst_terr", timeout_err, 0);
        chk("rst_ack", drv_ack, 0);
        reset_n = 1'b1;
        tick();

        // Single read from drive 1 with a full 512-cycle sector.
        run_txn(2'b10, 2'b00, {32'h0000_0123, 32'hDEAD_BEEF}, 16'h5AA5, 0, 512, 1'b0, 1'b0);
        // Held contention: served 0,1,0,1.
        repeat (4) run_txn(2'b11, 2'b00, {32'h1111_0001, 32'h2222_0002}, 16'h3C4B, 2, 3, 1'b0, 1'b1);
        // Write wins over read; data from the granted drive only.
        run_txn(2'b01, 2'b01, {32'h0BAD_F00D, 32'h0000_0777}, {8'h5A, 8'hA5}, 1, 6, 1'b0, 1'b0);
        // Host never answers.
        run_txn(2'b01, 2'b00, {32'h0000_0099, 32'h0000_0042}, 16'h1234, -1, 0, 1'b0, 1'b0);
        // Requester withdraws right after issue.
        run_txn(2'b01, 2'b00, {32'h0000_0055, 32'h0000_0066}, 16'h7788, 4, 2, 1'b1, 1'b0);

        for (int t = 0; t < 60; t++) begin
            rd = NDR'($urandom);
            wr = NDR'($urandom) & NDR'($urandom);
            if ($urandom_range(0, 9) == 0) begin
                rd = '0;
                wr = '0;
            end
            dly = ($urandom_range(0, 11) == 0) ? -1 : int'($urandom_range(0, 6));
            run_txn(rd, wr, {$urandom, $urandom}, 16'($urandom), dly,
                    int'($urandom_range(1, 6)), 1'($urandom), 1'($urandom));
        end

        // Asynchronous reset in the middle of a transfer.
        drv_rd = 2'b01;
        drv_wr = 2'b00;
        tick();
        sd_ack = 1'b1;
        tick();
        chk("pre_rst_ack", drv_ack[0], 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_dir", {sd_rd, sd_wr}, 0);
        chk("arst_busy", busy, 0);
        chk("arst_ack", drv_ack, 0);
        chk("arst_lba", sd_lba, 0);
        sd_ack = 1'b0;
        drv_rd = '0;
        tick();
        reset_n = 1'b1;
        last_srv = NDR - 1;
        tick();
        run_txn(2'b11, 2'b00, {32'h0000_0A0B, 32'h0000_0C0D}, 16'hBEEF, 1, 2, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
